// File: rtl/bdm_pkg.sv
// Shared opcodes and state encodings for the BDM command sequencer.
// The state encodings are also what the host uses to decode state_dbg.
package bdm_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_BOOT  = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_WRITE = 3'd3;
  localparam logic [2:0] OP_READ  = 3'd4;
  localparam logic [2:0] OP_DELAY = 3'd5;
  localparam logic [2:0] OP_ECHO  = 3'd6;
  localparam logic [2:0] OP_VPP   = 3'd7;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    BOOT    = 4'd1,
    SYNC    = 4'd2,
    TX_WAIT = 4'd3,
    TX_BUSY = 4'd4,
    RX_BUSY = 4'd5,
    RX_HOLD = 4'd6,
    DELAY   = 4'd7,
    ECHO    = 4'd8
  } state_t;

  // States in which the sequencer is waiting on the engine (watchdog armed).
  function automatic logic is_engine_wait(state_t s);
    return (s == BOOT) || (s == SYNC) || (s == TX_BUSY) || (s == RX_BUSY);
  endfunction

endpackage

// File: rtl/bdm_watchdog.sv
// Per-byte engine watchdog; present only when BDM_SEQ_TIMEOUT_EN is defined.
// expired is high while counting and the count sits at TIMEOUT_CYCLES-1.
`ifdef BDM_SEQ_TIMEOUT_EN
module bdm_watchdog #(
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] TERM = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (count_en && (cnt != TERM))
      cnt <= cnt + TIMEOUT_W'(1);
  end

  assign expired = count_en && (cnt == TERM);

endmodule
`endif

// File: rtl/bdm_cmd_sequencer.sv
// BDM command sequencer: runs opcode commands and multi-byte BDC bursts
// against the byte engine. Watchdog is built only with BDM_SEQ_TIMEOUT_EN.
module bdm_cmd_sequencer
  import bdm_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int LEN_W          = 4,
  parameter int DELAY_SHIFT    = 4,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_arg,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              eng_boot,
  input  logic              eng_boot_done,
  output logic              eng_sync,
  input  logic              eng_sync_done,
  output logic              eng_stop,
  output logic              eng_tx,
  output logic [DATA_W-1:0] eng_tx_data,
  output logic              eng_rx,
  input  logic [DATA_W-1:0] eng_rx_data,
  input  logic              eng_done,
  output logic              mcu_vpp,
  output logic              cmd_done,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [3:0]        state_dbg
);

  localparam int DLY_W = DATA_W + DELAY_SHIFT;

  state_t            state, state_n;
  logic [LEN_W-1:0]  rem, rem_n;
  logic [DLY_W-1:0]  dly, dly_n;
  logic              boot_n, sync_n, stop_n, tx_n, rx_n, done_n, vpp_n, rdv_n, err_n;
  logic [DATA_W-1:0] txd_n, rdd_n;
  logic              wd_expired;

`ifdef BDM_SEQ_TIMEOUT_EN
  bdm_watchdog #(
    .TIMEOUT_W     (TIMEOUT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (boot_n | sync_n | stop_n | tx_n | rx_n),
    .count_en(is_engine_wait(state)),
    .expired (wd_expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = err_clr ^ (TIMEOUT_W > 0) ^ (TIMEOUT_CYCLES > 0);
  assign wd_expired = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == TX_WAIT);
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    rem_n   = rem;
    dly_n   = dly;
    boot_n  = 1'b0;
    sync_n  = 1'b0;
    stop_n  = 1'b0;
    tx_n    = 1'b0;
    rx_n    = 1'b0;
    done_n  = 1'b0;
    vpp_n   = mcu_vpp;
    rdv_n   = rd_valid;
    rdd_n   = rd_data;
    txd_n   = eng_tx_data;
`ifdef BDM_SEQ_TIMEOUT_EN
    err_n   = err_timeout & ~err_clr;
`else
    err_n   = 1'b0;
`endif
    case (state)
      IDLE: if (cmd_valid) begin
        case (cmd_op)
          OP_NOP:  done_n = 1'b1;
          OP_BOOT: begin boot_n = 1'b1; state_n = BOOT; end
          OP_STOP: begin stop_n = 1'b1; done_n = 1'b1; end
          OP_WRITE:
            if (cmd_len == '0) done_n = 1'b1;
            else begin rem_n = cmd_len; state_n = TX_WAIT; end
          OP_READ:
            if (cmd_len == '0) done_n = 1'b1;
            else begin rem_n = cmd_len; rx_n = 1'b1; state_n = RX_BUSY; end
          OP_DELAY: begin dly_n = DLY_W'(cmd_arg) << DELAY_SHIFT; state_n = DELAY; end
          OP_ECHO:  begin rdd_n = cmd_arg; rdv_n = 1'b1; state_n = ECHO; end
          default:  begin vpp_n = cmd_arg[0]; done_n = 1'b1; end
        endcase
      end
      BOOT:
        if (eng_boot_done) begin sync_n = 1'b1; state_n = SYNC; end
      SYNC:
        if (eng_sync_done) begin done_n = 1'b1; state_n = IDLE; end
      TX_WAIT:
        if (wr_valid) begin txd_n = wr_data; tx_n = 1'b1; state_n = TX_BUSY; end
      TX_BUSY:
        if (eng_done) begin
          rem_n = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin done_n = 1'b1; state_n = IDLE; end
          else state_n = TX_WAIT;
        end
      RX_BUSY:
        if (eng_done) begin rdd_n = eng_rx_data; rdv_n = 1'b1; state_n = RX_HOLD; end
      RX_HOLD:
        if (rd_ready) begin
          rdv_n = 1'b0;
          rem_n = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin done_n = 1'b1; state_n = IDLE; end
          else begin rx_n = 1'b1; state_n = RX_BUSY; end
        end
      DELAY:
        if (dly == '0) begin done_n = 1'b1; state_n = IDLE; end
        else dly_n = dly - DLY_W'(1);
      ECHO:
        if (rd_ready) begin rdv_n = 1'b0; done_n = 1'b1; state_n = IDLE; end
      default: state_n = IDLE;
    endcase
    // A done arriving on the terminal count already moved us out above.
    if (wd_expired && (state_n == state)) begin
      err_n   = 1'b1;
      done_n  = 1'b1;
      rem_n   = '0;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      dly         <= '0;
      eng_boot    <= 1'b0;
      eng_sync    <= 1'b0;
      eng_stop    <= 1'b0;
      eng_tx      <= 1'b0;
      eng_rx      <= 1'b0;
      cmd_done    <= 1'b0;
      mcu_vpp     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      eng_tx_data <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      dly         <= dly_n;
      eng_boot    <= boot_n;
      eng_sync    <= sync_n;
      eng_stop    <= stop_n;
      eng_tx      <= tx_n;
      eng_rx      <= rx_n;
      cmd_done    <= done_n;
      mcu_vpp     <= vpp_n;
      rd_valid    <= rdv_n;
      rd_data     <= rdd_n;
      eng_tx_data <= txd_n;
      err_timeout <= err_n;
    end
  end

endmodule

// File: tb/tb_bdm_cmd_sequencer.sv
// Directed bench for bdm_cmd_sequencer; the timeout section depends on
// BDM_SEQ_TIMEOUT_EN matching the RTL build.
module tb_bdm_cmd_sequencer;
  import bdm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] cmd_arg = '0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       eng_boot, eng_boot_done = 1'b0, eng_sync, eng_sync_done = 1'b0, eng_stop;
  logic       eng_tx, eng_rx, eng_done = 1'b0;
  logic [7:0] eng_tx_data, eng_rx_data = '0;
  logic       mcu_vpp, cmd_done, err_timeout, err_clr = 1'b0;
  logic [3:0] state_dbg;

  int total = 0, bad = 0;
  int tx_cnt = 0, rx_cnt = 0, done_cnt = 0;
  int base_tx, base_rx, base_done, n;
  logic [7:0] wbytes [3] = '{8'hA5, 8'h5A, 8'h3C};

  bdm_cmd_sequencer #(.DATA_W(8), .LEN_W(4), .DELAY_SHIFT(4),
                      .TIMEOUT_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_arg(cmd_arg),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .eng_boot(eng_boot), .eng_boot_done(eng_boot_done),
    .eng_sync(eng_sync), .eng_sync_done(eng_sync_done), .eng_stop(eng_stop),
    .eng_tx(eng_tx), .eng_tx_data(eng_tx_data), .eng_rx(eng_rx),
    .eng_rx_data(eng_rx_data), .eng_done(eng_done), .mcu_vpp(mcu_vpp),
    .cmd_done(cmd_done), .err_timeout(err_timeout), .err_clr(err_clr),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (eng_tx)   tx_cnt   <= tx_cnt + 1;
    if (eng_rx)   rx_cnt   <= rx_cnt + 1;
    if (cmd_done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one command for a single cycle; returns in the cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [3:0] len, input logic [7:0] arg);
    cmd_op = op; cmd_len = len; cmd_arg = arg; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_outs", {eng_boot, eng_sync, eng_stop, eng_tx, eng_rx, rd_valid,
                       cmd_done, mcu_vpp, err_timeout}, 0);
    chk("reset_data", {rd_data, eng_tx_data, state_dbg}, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_ready", {cmd_ready, wr_ready}, 2'b10);

    issue(OP_NOP, 0, 0);
    chk("nop_done", cmd_done, 1);
    step();
    chk("nop_done_pulse", cmd_done, 0);

    issue(OP_VPP, 0, 8'h01);
    chk("vpp_set", {mcu_vpp, cmd_done}, 2'b11);
    issue(OP_STOP, 0, 0);
    chk("stop_strobe", {eng_stop, cmd_done, mcu_vpp}, 3'b111);
    step();
    chk("stop_pulse", eng_stop, 0);
    issue(OP_VPP, 0, 8'h00);
    chk("vpp_clr", mcu_vpp, 0);

    eng_done = 1'b1; eng_boot_done = 1'b1;
    step(); step();
    eng_done = 1'b0; eng_boot_done = 1'b0;
    chk("idle_ignores_eng", {state_dbg, rd_valid, eng_sync, cmd_done}, 0);

    // WRITE burst of 3, engine answers 4 cycles after each eng_tx
    base_tx = tx_cnt; base_done = done_cnt;
    issue(OP_WRITE, 3, 0);
    for (int i = 0; i < 3; i++) begin
      chk("wr_ready", wr_ready, 1);
      wr_valid = 1'b1; wr_data = wbytes[i];
      step();
      wr_valid = 1'b0;
      chk("tx_strobe", {eng_tx, eng_tx_data}, {1'b1, wbytes[i]});
      step(); step(); step();
      chk("tx_busy", {wr_ready, state_dbg}, {1'b0, TX_BUSY});
      step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      chk("tx_byte_retire", cmd_done, (i == 2) ? 1 : 0);
    end
    step();
    chk("tx_count", tx_cnt - base_tx, 3);
    chk("tx_done_count", done_cnt - base_done, 1);

    // READ burst of 2 with a 5-cycle host stall on the first byte
    base_rx = rx_cnt;
    issue(OP_READ, 2, 0);
    chk("rx_strobe1", {eng_rx, state_dbg}, {1'b1, RX_BUSY});
    step(); step();
    eng_rx_data = 8'h11; eng_done = 1'b1;
    step();
    eng_done = 1'b0; eng_rx_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      chk("rx_stall_hold", {rd_valid, rd_data, eng_rx}, {1'b1, 8'h11, 1'b0});
      step();
    end
    chk("rx_no_early_strobe", rx_cnt - base_rx, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("rx_strobe2", {eng_rx, rd_valid}, 2'b10);
    step(); step();
    eng_rx_data = 8'h22; eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("rx_byte2", {rd_valid, rd_data, cmd_done}, {1'b1, 8'h22, 1'b0});
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("rx_retire", {cmd_done, rd_valid, err_timeout, state_dbg}, {3'b100, IDLE});

    // BOOT / SYNC handshake
    issue(OP_BOOT, 0, 0);
    chk("boot_strobe", {eng_boot, cmd_ready, state_dbg}, {2'b10, BOOT});
    step(); step();
    eng_boot_done = 1'b1;
    step();
    eng_boot_done = 1'b0;
    chk("sync_strobe", {eng_sync, eng_boot, cmd_ready, state_dbg}, {3'b100, SYNC});
    step();
    eng_sync_done = 1'b1;
    step();
    eng_sync_done = 1'b0;
    chk("boot_retire", {cmd_done, cmd_ready, err_timeout}, 3'b110);

    // DELAY latency measured from acceptance cycle
    issue(OP_DELAY, 0, 8'd3);
    n = 1;
    while (!cmd_done && n < 100) begin step(); n++; end
    chk("delay3_latency", n, 50);
    issue(OP_DELAY, 0, 8'd0);
    n = 1;
    while (!cmd_done && n < 100) begin step(); n++; end
    chk("delay0_latency", n, 2);

    issue(OP_ECHO, 0, 8'h5C);
    chk("echo_valid", {rd_valid, rd_data}, {1'b1, 8'h5C});
    step(); step();
    chk("echo_hold", {rd_valid, rd_data, cmd_done}, {1'b1, 8'h5C, 1'b0});
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("echo_retire", {rd_valid, cmd_done}, 2'b01);

    base_tx = tx_cnt; base_rx = rx_cnt;
    issue(OP_WRITE, 0, 0);
    chk("write_len0", {cmd_done, eng_tx, state_dbg}, {2'b10, IDLE});
    issue(OP_READ, 0, 0);
    chk("read_len0", {cmd_done, eng_rx, state_dbg}, {2'b10, IDLE});
    step();
    chk("len0_no_strobes", (tx_cnt - base_tx) + (rx_cnt - base_rx), 0);

`ifdef BDM_SEQ_TIMEOUT_EN
    base_rx = rx_cnt;
    issue(OP_READ, 4, 0);
    n = 0;
    while (!err_timeout && n < 40) begin step(); n++; end
    chk("timeout_latency", n, 16);
    chk("timeout_abort", {cmd_done, state_dbg}, {1'b1, IDLE});
    step(); step(); step();
    chk("timeout_no_more_rx", {rx_cnt - base_rx, 28'd0}, {32'd1, 28'd0});
    chk("timeout_sticky", err_timeout, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("timeout_clear", err_timeout, 0);

    // eng_done on the terminal-count cycle beats the watchdog
    issue(OP_READ, 1, 0);
    for (int i = 0; i < 15; i++) step();
    eng_rx_data = 8'h77; eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("done_beats_timeout", {err_timeout, rd_valid, rd_data}, {2'b01, 8'h77});
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("done_beats_retire", {cmd_done, err_timeout}, 2'b10);
`else
    issue(OP_READ, 4, 0);
    for (int i = 0; i < 40; i++) step();
    chk("no_watchdog_wait", {err_timeout, state_dbg}, {1'b0, RX_BUSY});
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif

    // Asynchronous reset in the middle of a WRITE burst with VPP on
    issue(OP_VPP, 0, 8'h01);
    issue(OP_WRITE, 3, 0);
    wr_valid = 1'b1; wr_data = 8'hC3;
    step();
    wr_valid = 1'b0;
    chk("pre_reset", {mcu_vpp, eng_tx, eng_tx_data}, {2'b11, 8'hC3});
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outs", {mcu_vpp, eng_tx, eng_tx_data, state_dbg, cmd_done,
                             rd_valid, err_timeout}, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("post_reset_ready", {cmd_ready, state_dbg, mcu_vpp}, {1'b1, IDLE, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bdm_cmd_sequencer.md
Name: bdm_cmd_sequencer

Overview:
- Parametrised successor to the single-byte BDM front-end controller.
- Accepts opcode commands carrying a burst length, and runs multi-byte BDC write and read bursts against an external byte engine (BDC interface plus startup and sync controllers) through strobe/done handshakes.
- Adds a per-byte engine watchdog, streaming read/write data ports with backpressure, and scalable delays.
- Sits between the host command decoder and the BDC engine blocks.

Parameters:
- DATA_W, 8: byte width on all data paths.
- LEN_W, 4: width of the burst-length field; bursts are 0..2^LEN_W-1 bytes.
- DELAY_SHIFT, 4: delay in cycles = cmd_arg << DELAY_SHIFT.
- TIMEOUT_W, 16: width of the watchdog counter.
- TIMEOUT_CYCLES, 50000: number of cycles to wait for an engine done before aborting.

Ports:
- clk in 1: system clock.
- rst in 1: asynchronous, active-high reset.
- cmd_valid in 1: command present.
- cmd_ready out 1: sequencer is idle and accepts a command.
- cmd_op in 3: opcode.
- cmd_len in LEN_W: burst byte count.
- cmd_arg in DATA_W: delay amount, echo byte, or VPP enable (bit 0).
- wr_valid in 1, wr_data in DATA_W, wr_ready out 1: write-byte stream.
- rd_valid out 1, rd_data out DATA_W, rd_ready in 1: read-byte stream.
- eng_boot out 1, eng_boot_done in 1: startup controller strobe/done.
- eng_sync out 1, eng_sync_done in 1: sync strobe/done.
- eng_stop out 1: power-off strobe.
- eng_tx out 1, eng_tx_data out DATA_W, eng_rx out 1, eng_rx_data in DATA_W, eng_done in 1: BDC byte engine.
- mcu_vpp out 1: VPP enable level.
- cmd_done out 1: one-cycle pulse when a command retires.
- err_timeout out 1: sticky watchdog error.
- err_clr in 1: clears err_timeout.
- state_dbg out 4: current state encoding.

Behaviour:
- Reset: state IDLE; every strobe, rd_valid, cmd_done, mcu_vpp and err_timeout is 0; rd_data and eng_tx_data are 0.
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid && cmd_ready, and its fields are latched that cycle.
- Opcodes:
  - 0 NOP: cmd_done on the next cycle.
  - 1 BOOT: eng_boot pulse, go to BOOT. On eng_boot_done, eng_sync pulse and go to SYNC. On eng_sync_done, retire.
  - 2 STOP: eng_stop pulse, cmd_done on the next cycle.
  - 3 WRITE: burst of cmd_len bytes.
  - 4 READ: burst of cmd_len bytes.
  - 5 DELAY: load a counter of width DATA_W+DELAY_SHIFT with cmd_arg<<DELAY_SHIFT, decrement each cycle, retire on the cycle it is seen at 0. A load of 0 gives cmd_done 2 cycles after acceptance.
  - 6 ECHO: rd_data=cmd_arg, rd_valid held until rd_ready, then retire.
  - 7 VPP: mcu_vpp<=cmd_arg[0], cmd_done on the next cycle.
- WRITE states:
  - TX_WAIT: wr_ready=1. On wr_valid, latch wr_data into eng_tx_data, pulse eng_tx, go to TX_BUSY.
  - TX_BUSY: on eng_done, decrement the remaining count. If the count reaches 0, retire; otherwise return to TX_WAIT.
- READ states:
  - RX_BUSY: entered with an eng_rx pulse. On eng_done, capture eng_rx_data into rd_data, assert rd_valid, go to RX_HOLD.
  - RX_HOLD: rd_valid stays asserted until rd_ready, then decrement the count. Issue the next eng_rx or retire.
- cmd_len=0 on WRITE or READ: no engine strobe is issued, and cmd_done is asserted the cycle after acceptance.
- Watchdog:
  - Cleared on every engine strobe; counts only in BOOT, SYNC, TX_BUSY and RX_BUSY.
  - On reaching TIMEOUT_CYCLES-1: err_timeout<=1, abort the burst (remaining bytes dropped, no further strobes), cmd_done pulse, go to IDLE.
  - Host stalls (wr_valid low, rd_ready low) never time out.
- Simultaneous events:
  - eng_done in the same cycle as the timeout terminal count: done wins, no error.
  - err_clr and a new timeout in the same cycle: error wins, err_timeout stays 1.
- Strobes and cmd_done are single-cycle, registered.
- Engine inputs are ignored in IDLE.
- Asynchronous reset mid-burst drops the burst immediately; mcu_vpp returns to 0.

Optional Feature:
- Macro BDM_SEQ_TIMEOUT_EN.
  - Defined: watchdog present as specified above.
  - Undefined: no counter is instantiated, engine waits are unbounded, err_timeout is tied to 0, and err_clr is ignored.

Decomposition:
- Package bdm_pkg:
  - opcode localparams (OP_NOP..OP_VPP, 3 bits);
  - state encodings (IDLE, BOOT, SYNC, TX_WAIT, TX_BUSY, RX_BUSY, RX_HOLD, DELAY, ECHO), shared with state_dbg decoding in the host.
- Sub-module bdm_watchdog, wrapped by BDM_SEQ_TIMEOUT_EN:
  - inputs clear, count_en;
  - output expired;
  - parameters TIMEOUT_W, TIMEOUT_CYCLES.

Test Plan:
- WRITE, cmd_len=3, wr_data 0xA5, 0x5A, 0x3C, eng_done 4 cycles after each eng_tx -> eng_tx_data presents the 3 bytes in order; exactly 3 eng_tx pulses; a single cmd_done.
- READ, cmd_len=2, eng_rx_data 0x11 then 0x22, rd_ready held low 5 cycles on the first byte -> rd_valid/rd_data=0x11 stable through the stall; the second eng_rx is issued only after the handshake; no timeout.
- BOOT -> eng_boot, then eng_sync after eng_boot_done; cmd_done one cycle after eng_sync_done; cmd_ready low throughout.
- DELAY, cmd_arg=3, DELAY_SHIFT=4 -> cmd_done 50 cycles after acceptance (load 48, count to 0, retire cycle). cmd_arg=0 -> cmd_done 2 cycles after acceptance.
- Macro defined, TIMEOUT_CYCLES=16, READ len=4, eng_done never asserted -> err_timeout rises 16 cycles after eng_rx; cmd_done pulse; IDLE; err_clr drops it.
- rst asserted mid-WRITE with mcu_vpp=1 -> all outputs 0 asynchronously; cmd_ready=1 on the first clock after release.
